// File: rtl/pe_set_load_counter.sv
// Sequences the load cycles of a PE array: cycles_per_set load cycles for each of
// num_sets PE sets, with stall support and per-set / end-of-sequence pulses.
module pe_set_load_counter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned SET_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic [CNT_W-1:0] cycles_per_set,
    input  logic [SET_W-1:0] num_sets,
    output logic [CNT_W-1:0] cnt,
    output logic [SET_W-1:0] set_idx,
    output logic             busy,
    output logic             set_done,
    output logic             all_done,
    output logic             cfg_err
);

    typedef enum logic [0:0] {StIdle, StLoad} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [CNT_W-1:0] cps_q, cps_d;
    logic [SET_W-1:0] nsets_q, nsets_d;
    logic             cfg_err_q, cfg_err_d;
    logic             last_cnt, last_set, cfg_ok;

    // Limits are nonzero whenever LOAD is active, so limit-1 never underflows there.
    assign last_cnt = (cnt_q == cps_q - CNT_W'(1));
    assign last_set = (set_q == nsets_q - SET_W'(1));
    assign cfg_ok   = (cycles_per_set != '0) && (num_sets != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        set_d     = set_q;
        cps_d     = cps_q;
        nsets_d   = nsets_q;
        cfg_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                set_d = '0;
                if (start) begin
                    if (cfg_ok) begin
                        cps_d   = cycles_per_set;
                        nsets_d = num_sets;
                        state_d = StLoad;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (en) begin
                    if (last_cnt) begin
                        cnt_d = '0;
                        if (last_set) begin
                            set_d   = '0;
                            state_d = StIdle;
                        end else begin
                            set_d = set_q + SET_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            set_q     <= '0;
            cps_q     <= '0;
            nsets_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            set_q     <= set_d;
            cps_q     <= cps_d;
            nsets_q   <= nsets_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        cnt      = cnt_q;
        set_idx  = set_q;
        busy     = (state_q == StLoad);
        set_done = (state_q == StLoad) && en && last_cnt;
        all_done = set_done && last_set;
        cfg_err  = cfg_err_q;
    end

endmodule

// File: tb/tb_pe_set_load_counter.sv
// Directed bench for pe_set_load_counter: a vector table plus multi-cycle sequences
// for full runs, stalls, narrow counters, mid-run reset and back-to-back starts.
module tb_pe_set_load_counter;

    logic       clk = 1'b0;
    logic       rst, start, en;
    logic [7:0] cps;
    logic [3:0] ns;
    logic [7:0] cnt;
    logic [3:0] set_idx;
    logic       busy, set_done, all_done, cfg_err;

    logic       start4;
    logic [3:0] cps4, cnt4;
    logic [3:0] ns4, set4;
    logic       busy4, sd4, ad4, err4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_set_load_counter #(.CNT_W(8), .SET_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en),
        .cycles_per_set(cps), .num_sets(ns),
        .cnt(cnt), .set_idx(set_idx), .busy(busy),
        .set_done(set_done), .all_done(all_done), .cfg_err(cfg_err)
    );

    pe_set_load_counter #(.CNT_W(4), .SET_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .en(en),
        .cycles_per_set(cps4), .num_sets(ns4),
        .cnt(cnt4), .set_idx(set4), .busy(busy4),
        .set_done(sd4), .all_done(ad4), .cfg_err(err4)
    );

    typedef struct {
        logic       start;
        logic       en;
        logic [7:0] cps;
        logic [3:0] ns;
        logic [7:0] e_cnt;
        logic [3:0] e_set;
        logic       e_busy;
        logic       e_sd;
        logic       e_ad;
        logic       e_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " cnt"}, 32'(cnt), 32'd0);
        chk({tag, " set_idx"}, 32'(set_idx), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " set_done"}, 32'(set_done), 32'd0);
        chk({tag, " all_done"}, 32'(all_done), 32'd0);
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    // Runs one sequence from IDLE; optionally stalls 5 cycles at cnt=4 of set 1.
    task automatic run_seq(input logic [7:0] c, input logic [3:0] n, input bit stall,
                           output int nb, output int nsd, output int nad,
                           output int sdsum, output int adat, output int stall_err,
                           output int si10, output int si19);
        int  left;
        bit  stalled;
        nb = 0; nsd = 0; nad = 0; sdsum = 0; adat = -1; stall_err = 0;
        si10 = -1; si19 = -1; left = 0; stalled = 0;
        start = 1'b1; cps = c; ns = n; en = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (stall && !stalled && cnt == 8'd4 && set_idx == 4'd1) begin
                stalled = 1'b1;
                left    = 5;
            end
            en = (left == 0);
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (left > 0) begin
                if (cnt != 8'd4 || set_idx != 4'd1 || set_done || all_done) stall_err++;
                left--;
            end
            if (nb == 10) si10 = int'(set_idx);
            if (nb == 19) si19 = int'(set_idx);
            if (set_done) begin nsd++; sdsum += nb; end
            if (all_done) begin nad++; adat = nb; end
            tick();
        end
        en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, nsd, nad, sdsum, adat, serr, si10, si19, mx, wraps, prev, waited;

        vecs[0]  = '{1'b1, 1'b1, 8'd2, 4'd2, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'd2, 4'd2, 8'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'd2, 4'd2, 8'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'd2, 4'd2, 8'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 8'd7, 4'd7, 8'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'd7, 4'd7, 8'd1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'd0, 4'd3, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'd0, 4'd3, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'd0, 4'd3, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'd1, 4'd0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'd5, 4'd5, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'd1, 4'd1, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'd1, 4'd1, 8'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'd1, 4'd1, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset with start asserted: nothing may start.
        rst = 1'b1; start = 1'b1; en = 1'b1; cps = 8'd3; ns = 4'd2;
        start4 = 1'b0; cps4 = 4'd0; ns4 = 4'd0;
        tick();
        tick();
        @(negedge clk);
        chk_idle("reset");
        tick();
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post-reset busy", 32'(busy), 32'd0);
        tick();

        foreach (vecs[i]) begin
            start = vecs[i].start; en = vecs[i].en; cps = vecs[i].cps; ns = vecs[i].ns;
            @(negedge clk);
            chk($sformatf("v%0d cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d set_idx", i), 32'(set_idx), 32'(vecs[i].e_set));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d set_done", i), 32'(set_done), 32'(vecs[i].e_sd));
            chk($sformatf("v%0d all_done", i), 32'(all_done), 32'(vecs[i].e_ad));
            chk($sformatf("v%0d cfg_err", i), 32'(cfg_err), 32'(vecs[i].e_err));
            tick();
        end
        start = 1'b0;

        // 9 x 3 uninterrupted run.
        run_seq(8'd9, 4'd3, 1'b0, nb, nsd, nad, sdsum, adat, serr, si10, si19);
        chk("9x3 busy cycles", 32'(nb), 32'd27);
        chk("9x3 set_done count", 32'(nsd), 32'd3);
        chk("9x3 set_done cycle sum", 32'(sdsum), 32'd54);
        chk("9x3 all_done count", 32'(nad), 32'd1);
        chk("9x3 all_done cycle", 32'(adat), 32'd27);
        chk("9x3 set_idx@10", 32'(si10), 32'd1);
        chk("9x3 set_idx@19", 32'(si19), 32'd2);
        chk("9x3 end set_idx", 32'(set_idx), 32'd0);
        chk("9x3 end cnt", 32'(cnt), 32'd0);
        tick();

        // Same run with a 5-cycle stall at cnt=4 of set 1.
        run_seq(8'd9, 4'd3, 1'b1, nb, nsd, nad, sdsum, adat, serr, si10, si19);
        chk("stall busy cycles", 32'(nb), 32'd32);
        chk("stall set_done count", 32'(nsd), 32'd3);
        chk("stall set_done cycle sum", 32'(sdsum), 32'd64);
        chk("stall all_done count", 32'(nad), 32'd1);
        chk("stall hold errors", 32'(serr), 32'd0);
        tick();

        // Bad config then minimal 1x1 run.
        start = 1'b1; cps = 8'd0; ns = 4'd3;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("cfg0 cfg_err", 32'(cfg_err), 32'd1);
        chk("cfg0 busy", 32'(busy), 32'd0);
        tick();
        run_seq(8'd1, 4'd1, 1'b0, nb, nsd, nad, sdsum, adat, serr, si10, si19);
        chk("1x1 busy cycles", 32'(nb), 32'd1);
        chk("1x1 set_done count", 32'(nsd), 32'd1);
        chk("1x1 all_done cycle", 32'(adat), 32'd1);
        tick();

        // Narrow counter at its maximum legal limit.
        start4 = 1'b1; cps4 = 4'd15; ns4 = 4'd2; en = 1'b1;
        tick();
        start4 = 1'b0;
        nb = 0; nsd = 0; mx = 0; wraps = 0; prev = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy4) break;
            nb++;
            if (int'(cnt4) > mx) mx = int'(cnt4);
            if (prev == 14 && cnt4 == 4'd0) wraps++;
            prev = int'(cnt4);
            if (sd4) nsd++;
            tick();
        end
        chk("w4 busy cycles", 32'(nb), 32'd30);
        chk("w4 max cnt", 32'(mx), 32'd14);
        chk("w4 wraps", 32'(wraps), 32'd1);
        chk("w4 set_done count", 32'(nsd), 32'd2);
        tick();

        // Reset mid-run at cnt=5, set 2 of a 4-set run, with start asserted.
        start = 1'b1; cps = 8'd8; ns = 4'd4; en = 1'b1;
        tick();
        start = 1'b0;
        waited = 0;
        while (!(cnt == 8'd5 && set_idx == 4'd2) && waited < 100) begin
            tick();
            waited++;
        end
        chk("midrst reached target", 32'(waited < 100), 32'd1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("midrst all_done", 32'(all_done), 32'd0);
        tick();
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_idle("midrst");
        tick();
        @(negedge clk);
        chk("midrst stays idle", 32'(busy), 32'd0);
        tick();

        // start held across all_done: one IDLE cycle, then a fresh 3x1 run.
        start = 1'b1; cps = 8'd2; ns = 4'd1;
        tick();
        cps = 8'd3;
        @(negedge clk);
        chk("b2b A cnt0 busy", 32'(busy), 32'd1);
        chk("b2b A cnt0 set_done", 32'(set_done), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b A last cnt", 32'(cnt), 32'd1);
        chk("b2b A all_done", 32'(all_done), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b gap busy", 32'(busy), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b B busy", 32'(busy), 32'd1);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("b2b B cnt1 set_done", 32'(set_done), 32'd0);
        tick();
        @(negedge clk);
        chk("b2b B cnt", 32'(cnt), 32'd2);
        chk("b2b B all_done", 32'(all_done), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b end busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_set_load_counter.md
PE_SET_LOAD_COUNTER -- requirements
Module: pe_set_load_counter

Interface
REQ-001 Parameter CNT_W, default 8: width of the per-set cycle counter and of the cycles_per_set input.
REQ-002 Parameter SET_W, default 4: width of the PE-set index and of the num_sets input.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 Port start, input, 1 bit: request to begin a load sequence; honoured only in IDLE.
REQ-006 Port en, input, 1 bit: advance enable; when low in LOAD, all counters hold (stall).
REQ-007 Port cycles_per_set, input, CNT_W: p*q, the number of load cycles per PE set; sampled on accepted start.
REQ-008 Port num_sets, input, SET_W: number of PE sets to sequence; sampled on accepted start.
REQ-009 Port cnt, output, CNT_W: current cycle index within the active PE set.
REQ-010 Port set_idx, output, SET_W: index of the PE set currently being loaded.
REQ-011 Port busy, output, 1 bit: high while in LOAD.
REQ-012 Port set_done, output, 1 bit: one-cycle pulse on the final cycle of each PE set.
REQ-013 Port all_done, output, 1 bit: one-cycle pulse on the final cycle of the final PE set.
REQ-014 Port cfg_err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-015 FSM states: IDLE, LOAD; no other states.
REQ-016 IDLE -> LOAD on start=1 with cycles_per_set!=0 and num_sets!=0; cnt=0 and set_idx=0 on the first LOAD cycle; limits are latched internally.
REQ-017 start=1 in IDLE with cycles_per_set==0 or num_sets==0: stay IDLE, cfg_err=1 on the next cycle, all other outputs unchanged.
REQ-018 start while in LOAD is ignored; latched limits are not changed by input changes during LOAD.
REQ-019 In LOAD with en=1: cnt increments by 1 each cycle; at cnt==cycles_per_set-1, cnt wraps to 0 and set_idx increments.
REQ-020 set_done is asserted combinationally in the same cycle that cnt==cycles_per_set-1, en=1 and state is LOAD.
REQ-021 When set_done coincides with set_idx==num_sets-1: all_done=1 in the same cycle, the next state is IDLE, and cnt and set_idx return to 0.
REQ-022 In LOAD with en=0: cnt, set_idx and state hold; set_done and all_done stay 0.
REQ-023 Sequence length with en held high: exactly cycles_per_set*num_sets LOAD cycles; busy is high for exactly that many cycles.
REQ-024 Arithmetic is unsigned; cycles_per_set=2^CNT_W-1 and num_sets=2^SET_W-1 are legal with no overflow; neither counter exceeds its latched limit minus 1.
REQ-025 cycles_per_set=1: set_done is high on every enabled LOAD cycle and set_idx advances every enabled cycle.
REQ-026 In IDLE: cnt=0, set_idx=0, busy=0, set_done=0, all_done=0.
REQ-027 A new start is accepted on the cycle after all_done, giving back-to-back sequences with one IDLE cycle between them.

Reset
REQ-028 rst=1 at a rising edge forces state=IDLE, cnt=0, set_idx=0, busy=0, set_done=0, all_done=0 and cfg_err=0, regardless of start and en.
REQ-029 Reset mid-LOAD aborts the sequence with no all_done pulse; latched limits are discarded.
REQ-030 rst takes priority over start in the same cycle; no sequence starts.
REQ-031 Output values are defined only after the first reset edge.

Verification
REQ-032 cycles_per_set=9, num_sets=3, start pulse, en=1 -> busy high 27 cycles; set_done at LOAD cycles 9, 18 and 27; all_done at cycle 27 only; set_idx steps 0 -> 1 -> 2 -> 0.
REQ-033 Same configuration with en=0 for 5 cycles at cnt=4 of set 1 -> cnt stays 4 and set_idx stays 1 through the stall; busy lasts 32 cycles; pulse count unchanged.
REQ-034 cycles_per_set=0, num_sets=3, start -> cfg_err pulse one cycle later; busy stays 0; then cycles_per_set=1, num_sets=1, start -> busy for 1 cycle with set_done and all_done in that same cycle.
REQ-035 CNT_W=4, cycles_per_set=15, num_sets=2 -> cnt reaches 14 and wraps to 0; 30 busy cycles; no overflow to 15.
REQ-036 rst=1 at cnt=5, set_idx=2 of a 4-set run -> next cycle IDLE with all outputs 0 and no all_done; a start asserted during rst is ignored.
REQ-037 start held high across all_done -> a new sequence begins after exactly one IDLE cycle with limits re-sampled.
